dice_lights_monitor: RTL

- Passive protocol checker on the 3-bit result bus of the dice/traffic-lights multiplexer. Sits on the consumer side of that bus.
- Samples sel, button and result on every rising clk edge and predicts the next legal code for the active mode. Reports illegal codes, bad transitions and failure to lock.
- Used in-system as a health monitor and in benches as a self-checking scoreboard.

---
 rtl/dice_lights_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dice_lights_monitor.sv
// Passive checker for the dice / traffic-lights result bus: tracks the legal code
// sequence for the active mode and flags illegal codes, bad transitions and lock timeouts.
module dice_lights_monitor #(
    parameter int CNT_W       = 8,
    parameter int ACQ_TIMEOUT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sel,
    input  logic             i_button,
    input  logic [2:0]       i_result,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_err_pulse,
    output logic [1:0]       o_err_code,
    output logic [CNT_W-1:0] o_err_count,
    output logic [2:0]       o_last_code
);

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    localparam logic [3:0] ACQ_LIMIT = 4'(ACQ_TIMEOUT);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_acqCnt;
    logic [3:0] w_nextAcqCnt;
    logic [2:0] r_prevCode;
    logic       r_prevButton;
    logic       r_prevSel;
    logic       r_seen;

    logic       w_legal;
    logic       w_modeChange;
    logic       w_raise;
    logic [1:0] w_errType;
    logic [2:0] w_expected;

    always_comb begin
        w_legal = 1'b0;
        if (i_sel) begin
            w_legal = (i_result == 3'b100) || (i_result == 3'b110) ||
                      (i_result == 3'b001) || (i_result == 3'b010);
        end else begin
            w_legal = (i_result != 3'b000) && (i_result != 3'b111);
        end
    end

    // Successor of the previous sample; only meaningful when the mode did not change.
    always_comb begin
        w_expected = r_prevCode;
        if (i_sel) begin
            case (r_prevCode)
                3'b100:  w_expected = 3'b110;
                3'b110:  w_expected = 3'b001;
                3'b001:  w_expected = 3'b010;
                3'b010:  w_expected = 3'b100;
                default: w_expected = r_prevCode;
            endcase
        end else if (r_prevButton) begin
            w_expected = (r_prevCode == 3'b110) ? 3'b001 : r_prevCode + 3'd1;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextAcqCnt = r_acqCnt;
        w_raise      = 1'b0;
        w_errType    = 2'b00;
        w_modeChange = !r_seen || (i_sel != r_prevSel);
        // A mode change hides the other producer's history, so re-acquire silently.
        if (r_state == ST_ACQUIRE || w_modeChange) begin
            if (w_legal) begin
                w_nextState  = ST_TRACK;
                w_nextAcqCnt = 4'd0;
            end else begin
                w_nextState = ST_ACQUIRE;
                if (r_acqCnt + 4'd1 >= ACQ_LIMIT) begin
                    w_raise      = 1'b1;
                    w_errType    = 2'b11;
                    w_nextAcqCnt = 4'd0;
                end else begin
                    w_nextAcqCnt = r_acqCnt + 4'd1;
                end
            end
        end else if (!w_legal) begin
            w_raise      = 1'b1;
            w_errType    = 2'b01;
            w_nextState  = ST_ACQUIRE;
            w_nextAcqCnt = 4'd0;
        end else if (i_result != w_expected) begin
            w_raise   = 1'b1;
            w_errType = 2'b10;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_ACQUIRE;
            r_acqCnt     <= 4'd0;
            r_prevCode   <= 3'd0;
            r_prevButton <= 1'b0;
            r_prevSel    <= 1'b0;
            r_seen       <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_acqCnt     <= w_nextAcqCnt;
            r_prevCode   <= i_result;
            r_prevButton <= i_button;
            r_prevSel    <= i_sel;
            r_seen       <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
            o_err_pulse <= 1'b0;
            o_err_code  <= 2'b00;
            o_err_count <= '0;
            o_last_code <= 3'd0;
        end else begin
            o_locked    <= (w_nextState == ST_TRACK);
            o_err_pulse <= w_raise;
            o_last_code <= i_result;
            if (w_raise) begin
                o_err      <= 1'b1;
                o_err_code <= w_errType;
                if (o_err_count != '1) begin
                    o_err_count <= o_err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
